// File: rtl/complex_nr_acc_pkg.sv
// Shared widths and FSM encoding for the complex product accumulator.
package complex_nr_acc_pkg;

  localparam int unsigned OP_W  = 16;
  localparam int unsigned ACC_W = 24;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StAccum = 2'b01,
    StHold  = 2'b10
  } state_e;

endpackage

// File: rtl/complex_nr_acc_if.sv
// Product-in / sum-out valid-ready bundle for complex_nr_acc.
interface complex_nr_acc_if;
  import complex_nr_acc_pkg::*;

  logic             prod_val;
  logic             prod_rdy;
  logic [OP_W-1:0]  prod_re;
  logic [OP_W-1:0]  prod_im;
  logic             acc_val;
  logic             acc_rdy;
  logic [ACC_W-1:0] acc_re;
  logic [ACC_W-1:0] acc_im;
  logic [CNT_W-1:0] term_cnt;

  modport master (
    output prod_val, prod_re, prod_im, acc_rdy,
    input  prod_rdy, acc_val, acc_re, acc_im, term_cnt
  );

  modport slave (
    input  prod_val, prod_re, prod_im, acc_rdy,
    output prod_rdy, acc_val, acc_re, acc_im, term_cnt
  );

endinterface

// File: rtl/complex_nr_acc_ctrl.sv
// Frame FSM, handshakes and term counter; tells the datapath when to load or add.
module complex_nr_acc_ctrl
  import complex_nr_acc_pkg::*;
#(
  parameter int unsigned N_TERMS = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             sw_rst_i,
  input  logic             prod_val_i,
  input  logic             acc_rdy_i,
  output logic             prod_rdy_o,
  output logic             acc_val_o,
  output logic             load_o,
  output logic             add_o,
  output logic [CNT_W-1:0] term_cnt_o
);

  // One extra counter bit so a 256-term frame can be detected.
  localparam logic [CNT_W:0] NTerms = (CNT_W + 1)'(N_TERMS);

  state_e         state_q, state_d;
  logic [CNT_W:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_o  = 1'b0;
    add_o   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (prod_val_i) begin
          load_o  = 1'b1;
          cnt_d   = (CNT_W + 1)'(1);
          state_d = (cnt_d == NTerms) ? StHold : StAccum;
        end
      end
      StAccum: begin
        if (prod_val_i) begin
          add_o = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == NTerms) state_d = StHold;
        end
      end
      StHold: begin
        if (acc_rdy_i) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
    if (sw_rst_i) begin
      state_d = StIdle;
      cnt_d   = '0;
      load_o  = 1'b0;
      add_o   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign prod_rdy_o = (state_q != StHold);
  assign acc_val_o  = (state_q == StHold);
  assign term_cnt_o = cnt_q[CNT_W-1:0];

endmodule

// File: rtl/complex_nr_acc.sv
// Accumulates N_TERMS complex products per frame and presents the sum until taken.
module complex_nr_acc
  import complex_nr_acc_pkg::OP_W;
#(
  parameter int unsigned N_TERMS = 4,
  parameter int unsigned ACC_W   = 24
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       sw_rst,
  complex_nr_acc_if.slave bus
);

  logic             load, add;
  logic [ACC_W-1:0] re_ext, im_ext;
  logic [ACC_W-1:0] re_q, re_d, im_q, im_d;

  complex_nr_acc_ctrl #(
    .N_TERMS(N_TERMS)
  ) u_ctrl (
    .clk       (clk),
    .rstn      (rstn),
    .sw_rst_i  (sw_rst),
    .prod_val_i(bus.prod_val),
    .acc_rdy_i (bus.acc_rdy),
    .prod_rdy_o(bus.prod_rdy),
    .acc_val_o (bus.acc_val),
    .load_o    (load),
    .add_o     (add),
    .term_cnt_o(bus.term_cnt)
  );

  assign re_ext = {{(ACC_W - OP_W){bus.prod_re[OP_W-1]}}, bus.prod_re};
  assign im_ext = {{(ACC_W - OP_W){bus.prod_im[OP_W-1]}}, bus.prod_im};

  // Wrapping adds; a frame start loads instead of adding to the previous sum.
  always_comb begin
    re_d = re_q;
    im_d = im_q;
    if (sw_rst) begin
      re_d = '0;
      im_d = '0;
    end else if (load) begin
      re_d = re_ext;
      im_d = im_ext;
    end else if (add) begin
      re_d = re_q + re_ext;
      im_d = im_q + im_ext;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      re_q <= '0;
      im_q <= '0;
    end else begin
      re_q <= re_d;
      im_q <= im_d;
    end
  end

  assign bus.acc_re = re_q;
  assign bus.acc_im = im_q;

endmodule

// File: tb/tb_complex_nr_acc.sv
// Drives three instances (N_TERMS 4, 256, 1) with directed and random traffic.
module tb_complex_nr_acc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rstn;
  logic               sw  [3];
  logic               pv  [3];
  logic               ar  [3];
  logic signed [15:0] pre [3];
  logic signed [15:0] pim [3];
  logic               rdy [3];
  logic               val [3];
  logic [23:0]        are [3];
  logic [23:0]        aim [3];
  logic [7:0]         tc  [3];

  int errors = 0;
  int checks = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned NT = (g == 0) ? 4 : ((g == 1) ? 256 : 1);
    complex_nr_acc_if u_if ();
    complex_nr_acc #(
      .N_TERMS(NT),
      .ACC_W  (24)
    ) u_dut (
      .clk   (clk),
      .rstn  (rstn),
      .sw_rst(sw[g]),
      .bus   (u_if)
    );
    assign u_if.prod_val = pv[g];
    assign u_if.prod_re  = pre[g];
    assign u_if.prod_im  = pim[g];
    assign u_if.acc_rdy  = ar[g];
    assign rdy[g] = u_if.prod_rdy;
    assign val[g] = u_if.acc_val;
    assign are[g] = u_if.acc_re;
    assign aim[g] = u_if.acc_im;
    assign tc[g]  = u_if.term_cnt;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    chk(name, {63'b0, act}, {63'b0, exp});
  endtask

  task automatic chkw(input string name, input logic [23:0] act, input logic [23:0] exp);
    chk(name, {40'b0, act}, {40'b0, exp});
  endtask

  task automatic chkc(input string name, input logic [7:0] act, input logic [7:0] exp);
    chk(name, {56'b0, act}, {56'b0, exp});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int nt(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 256 : 1);
  endfunction

  // Frame-level reference: a frame is a list of accepted products, summed as integers.
  int   m_n  [3];
  int   m_sr [3];
  int   m_si [3];
  logic m_hold [3];
  bit   chk_en = 1'b0;

  always @(posedge clk or negedge rstn) begin
    for (int i = 0; i < 3; i++) begin
      if (!rstn || sw[i]) begin
        m_n[i]    <= 0;
        m_sr[i]   <= 0;
        m_si[i]   <= 0;
        m_hold[i] <= 1'b0;
      end else if (m_hold[i]) begin
        if (ar[i]) begin
          m_hold[i] <= 1'b0;
          m_n[i]    <= 0;
        end
      end else if (pv[i]) begin
        m_sr[i]   <= ((m_n[i] == 0) ? 0 : m_sr[i]) + int'(pre[i]);
        m_si[i]   <= ((m_n[i] == 0) ? 0 : m_si[i]) + int'(pim[i]);
        m_n[i]    <= m_n[i] + 1;
        m_hold[i] <= (m_n[i] + 1 == nt(i));
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("model_dut%0d", i),
            {6'b0, rdy[i], val[i], tc[i], are[i], aim[i]},
            {6'b0, ~m_hold[i], m_hold[i], m_n[i][7:0], m_sr[i][23:0], m_si[i][23:0]});
      end
    end
  end

  typedef struct {
    logic signed [15:0] re;
    logic signed [15:0] im;
    logic [23:0]        exp_re;
    logic [23:0]        exp_im;
    logic [7:0]         exp_cnt;
    logic               exp_val;
  } vec_t;

  vec_t tbl [4];
  logic signed [15:0] gap_re [4] = '{16'sd10, 16'sd5, -16'sd3, 16'sd100};
  logic signed [15:0] gap_im [4] = '{-16'sd20, 16'sd5, 16'sd7, 16'sd1};
  logic signed [15:0] fr_re  [4] = '{16'sd100, 16'sd300, -16'sd50, 16'sd7};
  logic signed [15:0] fr_im  [4] = '{16'sd200, 16'sd400, -16'sd60, -16'sd8};

  initial begin
    tbl[0] = '{16'sd1,  16'sd2,  24'd1,       24'd2,       8'd1, 1'b0};
    tbl[1] = '{16'sd3,  -16'sd4, 24'd4,       24'hFFFFFE,  8'd2, 1'b0};
    tbl[2] = '{-16'sd5, 16'sd6,  24'hFFFFFF,  24'd4,       8'd3, 1'b0};
    tbl[3] = '{16'sd7,  16'sd8,  24'd6,       24'd12,      8'd4, 1'b1};

    rstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sw[i] = 1'b0; pv[i] = 1'b0; ar[i] = 1'b0; pre[i] = '0; pim[i] = '0;
    end
    cyc();
    cyc();
    for (int i = 0; i < 3; i++) begin
      chkb("reset_rdy", rdy[i], 1'b1);
      chkb("reset_val", val[i], 1'b0);
      chkw("reset_re", are[i], 24'd0);
      chkw("reset_im", aim[i], 24'd0);
      chkc("reset_cnt", tc[i], 8'd0);
    end
    rstn = 1'b1;
    chk_en = 1'b1;
    cyc();

    // Back-to-back frame, running sum checked after each transfer.
    for (int k = 0; k < 4; k++) begin
      pv[0] = 1'b1; pre[0] = tbl[k].re; pim[0] = tbl[k].im;
      cyc();
      chkw("tbl_re", are[0], tbl[k].exp_re);
      chkw("tbl_im", aim[0], tbl[k].exp_im);
      chkc("tbl_cnt", tc[0], tbl[k].exp_cnt);
      chkb("tbl_val", val[0], tbl[k].exp_val);
    end
    pv[0] = 1'b0; ar[0] = 1'b1;
    cyc();
    chkb("tbl_out_val", val[0], 1'b0);
    chkb("tbl_out_rdy", rdy[0], 1'b1);
    chkc("tbl_out_cnt", tc[0], 8'd0);
    chkw("tbl_retain_re", are[0], 24'd6);
    ar[0] = 1'b0;

    // Gapped input, then a held result that ignores offered products.
    for (int k = 0; k < 4; k++) begin
      pv[0] = 1'b0;
      cyc();
      cyc();
      chkc("gap_cnt", tc[0], 8'(k));
      pv[0] = 1'b1; pre[0] = gap_re[k]; pim[0] = gap_im[k];
      cyc();
    end
    for (int h = 0; h < 5; h++) begin
      pv[0] = 1'b1; pre[0] = 16'sd999; pim[0] = 16'sd999;
      cyc();
      chkb("hold_val", val[0], 1'b1);
      chkb("hold_rdy", rdy[0], 1'b0);
      chkw("hold_re", are[0], 24'd112);
      chkw("hold_im", aim[0], 24'hFFFFF9);
      chkc("hold_cnt", tc[0], 8'd4);
    end
    pv[0] = 1'b0; ar[0] = 1'b1;
    cyc();
    chkb("hold_exit_rdy", rdy[0], 1'b1);
    chkb("hold_exit_val", val[0], 1'b0);
    ar[0] = 1'b0;

    // Full-scale 256-term frame reaches the extremes without wrapping.
    for (int k = 0; k < 256; k++) begin
      pv[1] = 1'b1; pre[1] = 16'sd32767; pim[1] = 16'h8000;
      cyc();
      if (k == 254) chkb("n256_early_val", val[1], 1'b0);
    end
    pv[1] = 1'b0;
    chkb("n256_val", val[1], 1'b1);
    chkw("n256_re", are[1], 24'h7FFF00);
    chkw("n256_im", aim[1], 24'h800000);
    chkc("n256_cnt", tc[1], 8'd0);  // 256 does not fit the 8-bit count field
    ar[1] = 1'b1;
    cyc();
    ar[1] = 1'b0;

    // Single-term frames must not add onto the previous result.
    pv[2] = 1'b1; pre[2] = -16'sd1; pim[2] = -16'sd1;
    cyc();
    chkb("n1_val", val[2], 1'b1);
    chkw("n1_re", are[2], 24'hFFFFFF);
    chkw("n1_im", aim[2], 24'hFFFFFF);
    chkc("n1_cnt", tc[2], 8'd1);
    pv[2] = 1'b0; ar[2] = 1'b1;
    cyc();
    chkb("n1_out_val", val[2], 1'b0);
    ar[2] = 1'b0; pv[2] = 1'b1; pre[2] = 16'sd2; pim[2] = 16'sd3;
    cyc();
    chkw("n1_fresh_re", are[2], 24'd2);
    chkw("n1_fresh_im", aim[2], 24'd3);
    pv[2] = 1'b0; ar[2] = 1'b1;
    cyc();
    ar[2] = 1'b0;

    // Software clear mid-frame beats a simultaneous transfer.
    for (int k = 1; k <= 2; k++) begin
      pv[0] = 1'b1; pre[0] = 16'(k); pim[0] = 16'(k);
      cyc();
    end
    sw[0] = 1'b1; pre[0] = 16'sd3; pim[0] = 16'sd3;
    cyc();
    chkb("sw_rdy", rdy[0], 1'b1);
    chkb("sw_val", val[0], 1'b0);
    chkw("sw_re", are[0], 24'd0);
    chkw("sw_im", aim[0], 24'd0);
    chkc("sw_cnt", tc[0], 8'd0);
    sw[0] = 1'b0; pv[0] = 1'b0;
    cyc();
    chkc("sw_after_cnt", tc[0], 8'd0);

    // Hardware reset while holding a result.
    for (int k = 0; k < 4; k++) begin
      pv[0] = 1'b1; pre[0] = 16'sd1; pim[0] = 16'sd1;
      cyc();
    end
    pv[0] = 1'b0;
    chkb("prerst_val", val[0], 1'b1);
    rstn = 1'b0;
    #1;
    chkb("rst_val", val[0], 1'b0);
    chkb("rst_rdy", rdy[0], 1'b1);
    chkw("rst_re", are[0], 24'd0);
    chkc("rst_cnt", tc[0], 8'd0);
    cyc();
    rstn = 1'b1;
    cyc();
    chkb("rst_after_val", val[0], 1'b0);
    for (int k = 0; k < 4; k++) begin
      pv[0] = 1'b1; pre[0] = fr_re[k]; pim[0] = fr_im[k];
      cyc();
    end
    pv[0] = 1'b0;
    chkb("recover_val", val[0], 1'b1);
    chkw("recover_re", are[0], 24'd357);
    chkw("recover_im", aim[0], 24'd532);
    ar[0] = 1'b1;
    cyc();
    ar[0] = 1'b0;

    // Random traffic on all instances against the frame model.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) begin
        pv[i]  = ($urandom_range(0, 9) < 7);
        ar[i]  = ($urandom_range(0, 1) == 1);
        sw[i]  = ($urandom_range(0, 49) == 0);
        pre[i] = 16'($urandom);
        pim[i] = 16'($urandom);
      end
      cyc();
    end
    for (int i = 0; i < 3; i++) begin
      pv[i] = 1'b0; ar[i] = 1'b0; sw[i] = 1'b0;
    end
    cyc();
    cyc();
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/complex_nr_acc.md
COMPLEX_NR_ACC -- requirements
Module: complex_nr_acc

Interface
REQ-001 SHALL have parameter N_TERMS, default 4, number of complex products summed per frame (legal 1..256).
REQ-002 SHALL have parameter ACC_W, default 24, accumulator width per component (fixed at 24 in this release).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 sw_rst  input  1  synchronous software clear, active-high.
REQ-006 prod_val  input  1  upstream multiplier result valid.
REQ-007 prod_rdy  output  1  block accepts a product this cycle.
REQ-008 prod_re  input  16  real part of product, two's complement.
REQ-009 prod_im  input  16  imaginary part of product, two's complement.
REQ-010 acc_val  output  1  accumulated sum valid.
REQ-011 acc_rdy  input  1  downstream accepts the sum.
REQ-012 acc_re  output  24  accumulated real sum, two's complement.
REQ-013 acc_im  output  24  accumulated imaginary sum, two's complement.
REQ-014 term_cnt  output  8  products accepted in current frame.

Function
REQ-015 Transfer in SHALL occur on a cycle with prod_val=1 and prod_rdy=1; transfer out on acc_val=1 and acc_rdy=1.
REQ-016 FSM states SHALL be IDLE, ACCUM, HOLD.
REQ-017 prod_rdy SHALL be 1 in IDLE and ACCUM, 0 in HOLD; acc_val SHALL be 1 only in HOLD.
REQ-018 IDLE: on transfer in, accumulators SHALL load sign-extended prod_re/prod_im (no add to stale value), term_cnt<=1; next state ACCUM, or HOLD if N_TERMS=1.
REQ-019 ACCUM: on transfer in, accumulators SHALL add sign-extended product, term_cnt+=1; next state HOLD when new term_cnt equals N_TERMS, else stay ACCUM.
REQ-020 No transfer in IDLE/ACCUM SHALL leave accumulators, term_cnt and state unchanged.
REQ-021 acc_val SHALL rise the cycle after the N_TERMS-th transfer in (latency 1); acc_re/acc_im SHALL stay stable while acc_val=1 and acc_rdy=0.
REQ-022 HOLD: on transfer out, next state IDLE, term_cnt<=0; accumulator values retained until next IDLE load.
REQ-023 Addition SHALL be modulo 2^24; no saturation; with N_TERMS<=256 no overflow is possible.
REQ-024 sw_rst=1 SHALL override every other event in the same cycle (including simultaneous transfer in/out): state IDLE, accumulators 0, term_cnt 0, any in-flight product dropped.
REQ-025 term_cnt SHALL read N_TERMS while in HOLD.

Reset
REQ-026 rstn=0 SHALL immediately force state IDLE, acc_re=0, acc_im=0, term_cnt=0, acc_val=0, prod_rdy=1 (asserted after reset release), regardless of clk.
REQ-027 Reset mid-frame or in HOLD SHALL discard partial sum with no acc_val pulse.

Structure
REQ-028 Shared package SHALL hold OP_W=16, ACC_W=24, CNT_W=8 and the FSM state encoding (IDLE=2'b00, ACCUM=2'b01, HOLD=2'b10).
REQ-029 FSM, handshake and term counter SHALL live in one sub-module complex_nr_acc_ctrl; datapath (sign-extend, adders, registers) in top.
REQ-030 All outputs SHALL be driven from registers or from state decode only; no combinational path from prod_val to prod_rdy or acc_rdy to acc_val.

Verification
REQ-031 N_TERMS=4, products (1,2),(3,-4),(-5,6),(7,8) back-to-back, acc_rdy=1 -> acc_val one cycle after 4th, acc_re=6, acc_im=12, term_cnt=4.
REQ-032 N_TERMS=4, prod_val gaps between products, acc_rdy=0 for 5 cycles -> sum unchanged and held, prod_rdy=0 throughout HOLD, IDLE after acc_rdy.
REQ-033 N_TERMS=256, all products (32767,-32768) -> acc_re=8388352 (0x7FFF00), acc_im=-8388608 (0x800000), no wrap.
REQ-034 N_TERMS=1, product (-1,-1) -> acc_re=acc_im=0xFFFFFF next cycle; second frame (2,3) -> 2,3 (no stale add).
REQ-035 sw_rst pulsed after 2 of 4 products, then rstn pulsed in HOLD -> each time IDLE, sums 0, term_cnt 0, no acc_val; following full frame sums correctly.
